// File: rtl/tick_gen_bank.sv
// Bank of independent programmable tick dividers with in-phase restart.
// Each channel counts enabled cycles and pulses tick once per divisor period,
// toggling tog so that it forms a divided clock of period 2*D.
// Divisor writes are staged and take effect only at the channel's next wrap,
// or immediately on sync, so a running period is never cut short.
module tick_gen_bank #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned CW       = 32,
  parameter int unsigned DIV_INIT = 12500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           div_wr,
  input  logic [3:0]     div_sel,
  input  logic [CW-1:0]  div_data,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] tog,
  output logic [NCH-1:0] div_pend
);

  // Per-channel state
  logic [CW-1:0]  cnt   [NCH];
  logic [CW-1:0]  d     [NCH];
  logic [CW-1:0]  p     [NCH];
  logic [CW-1:0]  last  [NCH];
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] wr_hit;

  // Terminal count, wrap detect and write-select decode per channel.
  // A divisor of 0 behaves like 1, so its terminal count is also 0.
  always_comb begin
    wrap   = '0;
    wr_hit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      last[i]   = (d[i] == '0) ? '0 : d[i] - CW'(1);
      wrap[i]   = en[i] && (cnt[i] == last[i]);
      // div_sel values at or above NCH match no channel and are dropped
      wr_hit[i] = div_wr && (div_sel == 4'(i));
    end
  end

  // Counter, divisor staging and output registers; rst beats sync beats count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]      <= '0;
        d[i]        <= CW'(DIV_INIT);
        p[i]        <= '0;
        div_pend[i] <= 1'b0;
        tick[i]     <= 1'b0;
        tog[i]      <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sync) begin
          cnt[i]      <= '0;
          tick[i]     <= 1'b0;
          tog[i]      <= 1'b0;
          div_pend[i] <= 1'b0;
          // A write coincident with sync bypasses staging entirely
          if (wr_hit[i]) begin
            d[i] <= div_data;
          end else if (div_pend[i]) begin
            d[i] <= p[i];
          end
        end else if (wrap[i]) begin
          cnt[i]      <= '0;
          tick[i]     <= 1'b1;
          tog[i]      <= ~tog[i];
          div_pend[i] <= 1'b0;
          // A write landing on the wrap edge is applied at this wrap
          if (wr_hit[i]) begin
            d[i] <= div_data;
          end else if (div_pend[i]) begin
            d[i] <= p[i];
          end
        end else begin
          tick[i] <= 1'b0;
          if (en[i]) begin
            cnt[i] <= cnt[i] + CW'(1);
          end
          // Later writes simply overwrite the staged value
          if (wr_hit[i]) begin
            p[i]        <= div_data;
            div_pend[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_bank.sv
// Directed bench for tick_gen_bank with NCH=3, CW=8, DIV_INIT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tick_gen_bank;

  logic       clk;
  logic       rst;
  logic [2:0] en;
  logic       sync;
  logic       div_wr;
  logic [3:0] div_sel;
  logic [7:0] div_data;
  logic [2:0] tick;
  logic [2:0] tog;
  logic [2:0] div_pend;

  int unsigned vectors;
  int unsigned miscompares;

  tick_gen_bank #(
    .NCH(3),
    .CW(8),
    .DIV_INIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sync(sync),
    .div_wr(div_wr),
    .div_sel(div_sel),
    .div_data(div_data),
    .tick(tick),
    .tog(tog),
    .div_pend(div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then land on the following falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] et, eg;
    rst = 1'b1; en = 3'b111; sync = 1'b1; div_wr = 1'b1; div_sel = 4'd0; div_data = 8'd1;
    step(); step();
    sync = 1'b0; div_wr = 1'b0;
    vectors++;
    if (tick !== 3'b000) begin miscompares++; $display("FAIL reset_tick got=%b exp=000", tick); end
    vectors++;
    if (tog !== 3'b000) begin miscompares++; $display("FAIL reset_tog got=%b exp=000", tog); end
    vectors++;
    if (div_pend !== 3'b000) begin miscompares++; $display("FAIL reset_pend got=%b exp=000", div_pend); end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      eg = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
      vectors++;
      if (tick !== et) begin miscompares++; $display("FAIL base_tick k=%0d got=%b exp=%b", k, tick, et); end
      vectors++;
      if (tog !== eg) begin miscompares++; $display("FAIL base_tog k=%0d got=%b exp=%b", k, tog, eg); end
    end
  endtask

  task automatic test_div_write();
    logic [2:0] et;
    logic       eg1;
    do_reset();
    en = 3'b111;
    step();                                   // edge 1
    div_wr = 1'b1; div_sel = 4'd1; div_data = 8'd2;
    step();                                   // edge 2
    div_wr = 1'b0;
    vectors++;
    if (div_pend !== 3'b010) begin miscompares++; $display("FAIL wr_pend_set got=%b exp=010", div_pend); end
    step();                                   // edge 3
    vectors++;
    if (div_pend !== 3'b010) begin miscompares++; $display("FAIL wr_pend_hold got=%b exp=010", div_pend); end
    step();                                   // edge 4: wrap applies D1=2
    vectors++;
    if (div_pend !== 3'b000) begin miscompares++; $display("FAIL wr_pend_clr got=%b exp=000", div_pend); end
    vectors++;
    if (tick !== 3'b111) begin miscompares++; $display("FAIL wr_wrap_tick got=%b exp=111", tick); end
    for (int k = 5; k <= 12; k++) begin
      step();
      et = {k % 4 == 0, k % 2 == 0, k % 4 == 0};
      eg1 = ((1 + (k - 4) / 2) % 2) == 1;
      vectors++;
      if (tick !== et) begin miscompares++; $display("FAIL wr_tick k=%0d got=%b exp=%b", k, tick, et); end
      vectors++;
      if (tog[1] !== eg1) begin miscompares++; $display("FAIL wr_tog1 k=%0d got=%b exp=%b", k, tog[1], eg1); end
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    en = 3'b111;
    step();                                   // edge 1: cnt=1
    en = 3'b011;
    for (int k = 2; k <= 4; k++) begin
      step();
      vectors++;
      if (tick[2] !== 1'b0 || tog[2] !== 1'b0) begin
        miscompares++; $display("FAIL gap_hold k=%0d got tick2=%b tog2=%b exp=0/0", k, tick[2], tog[2]);
      end
    end
    vectors++;
    if (tick !== 3'b011) begin miscompares++; $display("FAIL gap_others got=%b exp=011", tick); end
    en = 3'b111;
    step(); step();                           // edges 5, 6
    vectors++;
    if (tick !== 3'b000) begin miscompares++; $display("FAIL gap_pre got=%b exp=000", tick); end
    step();                                   // edge 7: ch2 wraps 3 cycles late
    vectors++;
    if (tick !== 3'b100) begin miscompares++; $display("FAIL gap_tick got=%b exp=100", tick); end
    vectors++;
    if (tog !== 3'b111) begin miscompares++; $display("FAIL gap_tog got=%b exp=111", tog); end
  endtask

  task automatic test_sync();
    logic [2:0] et;
    do_reset();
    en = 3'b111;
    step();                                   // edge 1
    div_wr = 1'b1; div_sel = 4'd0; div_data = 8'd6;
    step();                                   // edge 2
    div_data = 8'd3;
    step();                                   // edge 3: overwrite P0
    div_wr = 1'b0;
    vectors++;
    if (div_pend !== 3'b001) begin miscompares++; $display("FAIL sync_pre_pend got=%b exp=001", div_pend); end
    sync = 1'b1;
    step();                                   // edge 4: sync beats the wrap
    sync = 1'b0;
    vectors++;
    if (tick !== 3'b000 || tog !== 3'b000 || div_pend !== 3'b000) begin
      miscompares++; $display("FAIL sync_clear got tick=%b tog=%b pend=%b exp=000/000/000", tick, tog, div_pend);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      et = {k % 4 == 0, k % 4 == 0, k % 3 == 0};
      vectors++;
      if (tick !== et) begin miscompares++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  task automatic test_sync_write();
    logic [2:0] et;
    do_reset();
    en = 3'b111;
    step();                                   // edge 1
    div_wr = 1'b1; div_sel = 4'd3; div_data = 8'd1;
    step();                                   // out-of-range select
    div_wr = 1'b0;
    vectors++;
    if (div_pend !== 3'b000) begin miscompares++; $display("FAIL bad_sel_pend got=%b exp=000", div_pend); end
    sync = 1'b1; div_wr = 1'b1; div_sel = 4'd2; div_data = 8'd2;
    step();
    sync = 1'b0; div_wr = 1'b0;
    vectors++;
    if (div_pend !== 3'b000 || tick !== 3'b000) begin
      miscompares++; $display("FAIL syncwr_clear got pend=%b tick=%b exp=000/000", div_pend, tick);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      et = {k % 2 == 0, k % 4 == 0, k % 4 == 0};
      vectors++;
      if (tick !== et) begin miscompares++; $display("FAIL syncwr_tick k=%0d got=%b exp=%b", k, tick, et); end
    end
  endtask

  task automatic test_div_zero();
    logic [2:0] et;
    logic       eg1;
    do_reset();
    en = 3'b111;
    step();                                   // edge 1
    div_wr = 1'b1; div_sel = 4'd1; div_data = 8'd0;
    step();                                   // edge 2
    div_wr = 1'b0;
    step(); step();                           // edges 3, 4: wrap applies D1=0
    for (int k = 5; k <= 8; k++) begin
      step();
      et = {k % 4 == 0, 1'b1, k % 4 == 0};
      eg1 = ((k - 3) % 2) == 1;
      vectors++;
      if (tick !== et) begin miscompares++; $display("FAIL zero_tick k=%0d got=%b exp=%b", k, tick, et); end
      vectors++;
      if (tog[1] !== eg1) begin miscompares++; $display("FAIL zero_tog1 k=%0d got=%b exp=%b", k, tog[1], eg1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] et;
    do_reset();
    en = 3'b111;
    step();                                   // edge 1
    div_wr = 1'b1; div_sel = 4'd2; div_data = 8'd7;
    step();                                   // edge 2: cnt=2, pending on ch2
    vectors++;
    if (div_pend !== 3'b100) begin miscompares++; $display("FAIL mid_pend got=%b exp=100", div_pend); end
    rst = 1'b1; div_sel = 4'd0; div_data = 8'd1;
    step();
    rst = 1'b0; div_wr = 1'b0;
    vectors++;
    if (tick !== 3'b000 || tog !== 3'b000 || div_pend !== 3'b000) begin
      miscompares++; $display("FAIL mid_clear got tick=%b tog=%b pend=%b exp=000/000/000", tick, tog, div_pend);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      vectors++;
      if (tick !== et || div_pend !== 3'b000) begin
        miscompares++; $display("FAIL mid_tick k=%0d got tick=%b pend=%b exp=%b/000", k, tick, div_pend, et);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
    step();
    test_reset();
    test_div_write();
    test_enable_gap();
    test_sync();
    test_sync_write();
    test_div_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
